// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests to imem, a small
// shift FIFO of {pc, inst} toward decode, redirect flush with stale-drop, ecall halt.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc, resp_pc;
    logic [CW-1:0] count, outstanding, drop_cnt;
    logic          halt_q;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic [CW:0]   credit_used;
    logic          accept, resp, drop, push, pop;
    logic [CW-1:0] out_next, wr_idx;
    logic [31:0]   redirect_aligned;

    // Credits cover both in-flight and buffered words, so the FIFO can never overflow.
    assign credit_used      = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid   = !reset && !halt_q && !halt && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr    = fetch_pc;
    assign inst_valid       = (count != '0);
    assign inst             = q_inst[0];
    assign inst_pc          = q_pc[0];

    assign accept           = imem_req_valid && imem_req_ready;
    assign resp             = imem_resp_valid && (outstanding != '0);
    assign drop             = resp && (drop_cnt != '0);
    assign push             = resp && !drop && !redirect_valid;
    assign pop              = inst_valid && inst_ready;
    assign out_next         = outstanding + CW'(accept) - CW'(resp);
    assign wr_idx           = count - CW'(pop);
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            halt_q      <= 1'b0;
            halted      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= RESET_PC;
            end
        end else begin
            outstanding <= out_next;
            halt_q      <= halt_q || halt;
            halted      <= (halt_q || halt) && (out_next == '0);
            if (redirect_valid) begin
                // Everything still in flight, including a response landing now, is stale.
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                count    <= '0;
                drop_cnt <= out_next;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (drop)
                    drop_cnt <= drop_cnt - CW'(1);
                if (push)
                    resp_pc <= resp_pc + 32'd4;
                count <= count + CW'(push) - CW'(pop);
                // Entry 0 is the head; a pop shifts down and a push lands behind the survivors.
                for (int i = 0; i < DEPTH; i++) begin
                    if (pop && (i < DEPTH - 1)) begin
                        q_inst[i] <= q_inst[(i + 1 < DEPTH) ? i + 1 : i];
                        q_pc[i]   <= q_pc[(i + 1 < DEPTH) ? i + 1 : i];
                    end
                    if (push && (CW'(i) == wr_idx)) begin
                        q_inst[i] <= imem_resp_data;
                        q_pc[i]   <= resp_pc;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Random bench for inst_fetch_unit: a latency-randomised imem model plus a queue-based
// reference of pending requests and buffered words, checked every cycle.
module tb_inst_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt, halted;

    inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct { logic [31:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } buf_t;

    mem_t        mem_q[$];
    pend_t       pq[$];
    buf_t        bq[$];
    logic [31:0] fpc;
    bit          halt_m, halted_m, drain;
    int          cyc, ntests, nfail;
    logic [31:0] tgt[5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic cycle(input int p_rdy, input int p_ird, input int p_redir,
                         input int p_halt, input bit rst_i, input int max_lat);
        bit    rv, acc, exp_rv;
        pend_t p;
        reset          = rst_i;
        imem_req_ready = ($urandom_range(99) < p_rdy) && !drain;
        inst_ready     = ($urandom_range(99) < p_ird);
        redirect_valid = !rst_i && ($urandom_range(99) < p_redir);
        tgt[4]         = $urandom;
        redirect_pc    = tgt[$urandom_range(4)];
        halt           = !rst_i && ($urandom_range(99) < p_halt);
        rv             = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = rv;
        imem_resp_data  = rv ? mdata(mem_q[0].addr) : $urandom;
        #1;
        // imem side: follows the DUT's actual handshake
        if (rv) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready)
            mem_q.push_back('{imem_req_addr, cyc + $urandom_range(max_lat, 1)});
        if (rst_i) begin
            chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
            pq.delete(); bq.delete();
            fpc = RESET_PC; halt_m = 0; halted_m = 0; drain = 1;
        end else begin
            exp_rv = !halt_m && !halt && !redirect_valid && (pq.size() + bq.size() < DEPTH);
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
            chk("req_addr", imem_req_addr, fpc);
            acc = exp_rv && imem_req_ready;
            if (inst_ready && bq.size() > 0) void'(bq.pop_front());
            if (imem_resp_valid && pq.size() > 0) begin
                p = pq.pop_front();
                if (!p.stale && !redirect_valid) bq.push_back('{p.addr, imem_resp_data});
            end
            if (redirect_valid) begin
                bq.delete();
                foreach (pq[i]) pq[i].stale = 1;
                fpc = {redirect_pc[31:2], 2'b00};
            end
            if (acc) begin
                pq.push_back('{fpc, 1'b0});
                fpc = fpc + 32'd4;
            end
            halt_m   = halt_m || halt;
            halted_m = halt_m && (pq.size() == 0);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (drain && mem_q.size() == 0) drain = 0;
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, (bq.size() > 0)});
        if (bq.size() > 0) begin
            chk("inst", inst, bq[0].data);
            chk("inst_pc", inst_pc, bq[0].pc);
        end
        if (rst_i) begin
            chk("inst_reset", inst, 32'd0);
            chk("inst_pc_reset", inst_pc, RESET_PC);
        end
        chk("halted", {31'b0, halted}, {31'b0, halted_m});
    endtask

    initial begin
        tgt[0] = 32'h100; tgt[1] = 32'h103; tgt[2] = 32'hFFFF_FFFC; tgt[3] = 32'hFFFF_FFF8; tgt[4] = 0;
        cyc = 0; ntests = 0; nfail = 0; drain = 0;
        fpc = RESET_PC; halt_m = 0; halted_m = 0;
        reset = 1; imem_req_ready = 0; inst_ready = 0; redirect_valid = 0;
        redirect_pc = 0; halt = 0; imem_resp_valid = 0; imem_resp_data = 0;
        @(posedge clk); #1;
        repeat (3)  cycle(100, 100, 0, 0, 1, 1);
        // steady stream, 1-cycle memory
        repeat (40) cycle(100, 100, 0, 0, 0, 1);
        // decode stall then release
        repeat (10) cycle(100, 0, 0, 0, 0, 1);
        repeat (20) cycle(100, 100, 0, 0, 0, 1);
        // mixed traffic with redirects (incl. misaligned and wrapping targets)
        repeat (400) cycle(70, 70, 6, 0, 0, 3);
        repeat (60) cycle(100, 100, 15, 0, 0, 1);
        // reset mid-stream with late responses
        repeat (8)  cycle(100, 20, 0, 0, 0, 3);
        repeat (2)  cycle(100, 100, 0, 0, 1, 3);
        repeat (40) cycle(80, 80, 4, 0, 0, 2);
        // halt with traffic in flight, then drain
        repeat (10) cycle(100, 50, 0, 0, 0, 3);
        cycle(100, 50, 0, 100, 0, 3);
        repeat (40) cycle(100, 60, 5, 0, 0, 3);
        // reset clears halt; fetch restarts at RESET_PC
        repeat (2)  cycle(100, 100, 0, 0, 1, 1);
        repeat (30) cycle(100, 100, 0, 0, 0, 1);
        repeat (200) cycle(60, 60, 5, 1, 0, 4);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
